// File: rtl/rv151_pkg.sv
// Shared RV151 constants: immediate type codes, error counter width, and a
// helper used by the immediate encoder/decoder to test signed ranges.
package rv151_pkg;

    // Immediate type codes carried on in_tp; any other code means R (no imm).
    localparam logic [2:0] IMM_R = 3'h0;
    localparam logic [2:0] IMM_I = 3'h1;
    localparam logic [2:0] IMM_S = 3'h2;
    localparam logic [2:0] IMM_B = 3'h3;
    localparam logic [2:0] IMM_U = 3'h4;
    localparam logic [2:0] IMM_J = 3'h5;

    localparam int unsigned ERR_CNT_W = 16;

    // True when v fits in an n-bit two's complement field, i.e. v[31:n-1]
    // are all copies of the sign bit.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (n - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/rv151_imm_enc_if.sv
// Request/response bus of the immediate encoder.
//   in_valid/in_ready : request handshake
//   in_tp/in_imm/in_base : immediate type, value, instruction template
//   out_valid/out_ready : result handshake
//   out_inst/out_err : encoded instruction, not-representable flag
// slave = encoder side, master = requester/consumer side.
interface rv151_imm_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_tp;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport slave (
        input  in_valid, in_tp, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

    modport master (
        output in_valid, in_tp, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/rv151_imm_pack.sv
// Combinational check+pack: overwrite the immediate fields of base with imm
// according to tp and flag an imm that the format cannot represent. The
// truncated fields are packed even when err is set.
//   tp   : immediate type code (rv151_pkg IMM_*)
//   imm  : immediate value, two's complement
//   base : instruction template
//   inst : packed instruction
//   err  : imm not representable for tp
module rv151_imm_pack
    import rv151_pkg::*;
(
    input  logic [2:0]  tp,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        inst = base;
        err  = 1'b0;
        case (tp)
            IMM_I: begin
                inst[31:20] = imm[11:0];
                err         = !fits_signed(imm, 12);
            end
            IMM_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err         = !fits_signed(imm, 12);
            end
            IMM_B: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                err         = imm[0] || !fits_signed(imm, 13);
            end
            IMM_U: begin
                inst[31:12] = imm[31:12];
                err         = |imm[11:0];
            end
            IMM_J: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                err         = imm[0] || !fits_signed(imm, 21);
            end
            default: begin
                err = |imm;
            end
        endcase
    end

endmodule

// File: rtl/rv151_imm_enc.sv
// RISC-V immediate encoder: two-stage valid/ready pipeline around
// rv151_imm_pack (S1 = check+pack result, S2 = output register) plus a
// saturating count of errored results handed to the consumer.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : request/result handshake (rv151_imm_enc_if.slave)
//   err_cnt : saturating count of delivered results with out_err=1
module rv151_imm_enc
    import rv151_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rv151_imm_enc_if.slave       bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic        s1_valid;
    logic [31:0] s1_inst;
    logic        s1_err;
    logic        s2_valid;
    logic [31:0] s2_inst;
    logic        s2_err;

    logic [31:0] pk_inst;
    logic        pk_err;
    logic        s2_load;
    logic        s1_adv;

    rv151_imm_pack u_pack (
        .tp   (bus.in_tp),
        .imm  (bus.in_imm),
        .base (bus.in_base),
        .inst (pk_inst),
        .err  (pk_err)
    );

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_adv  = !s1_valid || s2_load;

    // Outputs are forced idle while rst is high so no handshake can
    // complete in the reset cycle, even though the registers clear only
    // at the edge.
    assign bus.in_ready  = s1_adv && !rst;
    assign bus.out_valid = s2_valid && !rst;
    assign bus.out_inst  = rst ? '0 : s2_inst;
    assign bus.out_err   = s2_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_inst  <= '0;
            s2_err   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_inst <= pk_inst;
                    s1_err  <= pk_err;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_inst <= s1_inst;
                    s2_err  <= s1_err;
                end
            end
            if (s2_valid && bus.out_ready && s2_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv151_imm_enc.sv
// Self-checking bench for rv151_imm_enc: directed vectors with hand-computed
// results, stall/back-pressure, mid-flight reset, and a short random phase
// checked by decoding the instruction back to the immediate.
module tb_rv151_imm_enc;
    import rv151_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] err_cnt;

    rv151_imm_enc_if bus ();

    rv151_imm_enc dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tp;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] inst;
        logic        err;
        logic        has_inst;
        logic        chk_lat;
        int          acc_cyc;
    } item_t;

    item_t       q[$];
    item_t       cur;
    int          n_checks = 0;
    int          n_errs = 0;
    int          cyc = 0;
    int unsigned model_cnt = 0;
    logic        acc = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_inst;
    logic        stall_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic fits(input logic [31:0] v, input int n);
        longint s;
        longint lim;
        s   = longint'($signed(v));
        lim = longint'(1) << (n - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    function automatic logic model_err(input logic [2:0] tp, input logic [31:0] v);
        case (tp)
            3'h1, 3'h2: return !fits(v, 12);
            3'h3:       return v[0] || !fits(v, 13);
            3'h4:       return v[11:0] != 12'h0;
            3'h5:       return v[0] || !fits(v, 21);
            default:    return v != 32'h0;
        endcase
    endfunction

    // Immediate recovered from an instruction, RISC-V field layout.
    function automatic logic [31:0] dec(input logic [2:0] tp, input logic [31:0] i);
        case (tp)
            3'h1:    return {{20{i[31]}}, i[31:20]};
            3'h2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'h3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'h4:    return {i[31:12], 12'h000};
            3'h5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Bits that must come straight from base.
    function automatic logic [31:0] keep_mask(input logic [2:0] tp);
        case (tp)
            3'h1:       return 32'h000F_FFFF;
            3'h2, 3'h3: return 32'h01FF_F07F;
            3'h4, 3'h5: return 32'h0000_0FFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    // One clock: observe handshakes at negedge+1, let the edge pass, return
    // at the next negedge for the caller to change inputs.
    task automatic cycle();
        item_t it;
        #1;
        acc = bus.in_valid && bus.in_ready;
        check("err_cnt", 32'(err_cnt), model_cnt);
        if (stall_prev) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_inst", bus.out_inst, stall_inst);
            check("hold_err", 32'(bus.out_err), 32'(stall_err));
        end
        stall_prev = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                it = q.pop_front();
                check("out_err", 32'(bus.out_err), 32'(it.err));
                if (it.has_inst) begin
                    check("out_inst", bus.out_inst, it.inst);
                end else begin
                    check("keep_base", bus.out_inst & keep_mask(it.tp), it.base & keep_mask(it.tp));
                    if (!it.err) check("decode", dec(it.tp, bus.out_inst), it.imm);
                end
                if (it.chk_lat) check("latency", 32'(cyc - it.acc_cyc), 32'd2);
                if (it.err && model_cnt < 32'hFFFF) model_cnt++;
            end
        end else if (bus.out_valid) begin
            stall_prev = 1'b1;
            stall_inst = bus.out_inst;
            stall_err  = bus.out_err;
        end
        if (acc) begin
            it = cur;
            it.acc_cyc = cyc;
            q.push_back(it);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [2:0] tp, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] inst, input logic err, input logic has_inst,
                        input logic chk_lat);
        cur.tp = tp; cur.imm = imm; cur.base = base; cur.inst = inst;
        cur.err = err; cur.has_inst = has_inst; cur.chk_lat = chk_lat; cur.acc_cyc = 0;
        bus.in_tp = tp; bus.in_imm = imm; bus.in_base = base; bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (acc) return;
        end
        check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_rnd();
        logic [2:0]  tp;
        logic [31:0] imm;
        tp = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
            default: imm = $urandom & 32'hFFFF_F000;
        endcase
        send(tp, imm, $urandom, 32'h0, model_err(tp, imm), 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_tp = 3'h0; bus.in_imm = '0; bus.in_base = '0;
        bus.out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Directed vectors, back-to-back with out_ready held high.
        send(IMM_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 1'b1, 1'b1);
        send(IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 1'b1, 1'b1);
        send(IMM_B, 32'h0000_0005, 32'h0000_0063, 32'h0000_0263, 1'b1, 1'b1, 1'b1);
        send(IMM_B, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0, 1'b1, 1'b1);
        send(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0, 1'b1, 1'b1);
        send(IMM_J, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0, 1'b1, 1'b1);
        send(IMM_S, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0, 1'b1, 1'b1);
        send(IMM_S, 32'h0000_07FF, 32'h0000_0000, 32'h7E00_0F80, 1'b0, 1'b1, 1'b1);
        send(IMM_R, 32'h0000_0000, 32'h0000_0033, 32'h0000_0033, 1'b0, 1'b1, 1'b1);
        send(3'h7,  32'h0000_0001, 32'h0000_0033, 32'h0000_0033, 1'b1, 1'b1, 1'b1);
        send(IMM_U, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1, 1'b1, 1'b1);
        send(IMM_J, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("err_cnt_directed", 32'(err_cnt), 32'd5);

        // Back-pressure: two items fill the pipe, the third must wait.
        bus.out_ready = 1'b0;
        send(IMM_I, 32'h1, 32'h13, 32'h0010_0013, 1'b0, 1'b1, 1'b0);
        send(IMM_I, 32'h2, 32'h13, 32'h0020_0013, 1'b0, 1'b1, 1'b0);
        cur.tp = IMM_I; cur.imm = 32'h3; cur.base = 32'h13; cur.inst = 32'h0030_0013;
        cur.err = 1'b0; cur.has_inst = 1'b1; cur.chk_lat = 1'b0;
        bus.in_tp = IMM_I; bus.in_imm = 32'h3; bus.in_base = 32'h13; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("full_no_accept", 32'(acc), 32'd0);
        end
        bus.out_ready = 1'b1;
        send(IMM_I, 32'h3, 32'h13, 32'h0030_0013, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("stall_drained", 32'(q.size()), 32'd0);

        // Reset with both stages full discards everything.
        bus.out_ready = 1'b0;
        send(IMM_I, 32'h4, 32'h13, 32'h0040_0013, 1'b0, 1'b1, 1'b0);
        send(IMM_B, 32'h1, 32'h63, 32'h0000_0063, 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        stall_prev = 1'b0;
        rst = 1'b1;
        #1 check("rst_cycle_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_cnt = 0;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        idle(5);

        // Random types/immediates with random output stalls.
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) send_rnd();
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
        idle(2);
        check("final_drain", 32'(q.size()), 32'd0);
        check("final_err_cnt", 32'(err_cnt), model_cnt);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
